// File: rtl/ifetch_prefetch_if.sv
// Refill-port and memory-port signals of ifetch_prefetch, bundled as one interface.
// The prefetch buffer uses the master modport; the core/memory environment uses slave.
interface ifetch_prefetch_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] o_data;
    logic            o_ready;
    logic            o_mem_req;
    logic [XLEN-1:0] o_mem_addr;
    logic [XLEN-1:0] i_mem_data;
    logic            i_mem_ready;

    modport master (
        input  i_req, i_addr, i_mem_data, i_mem_ready,
        output o_data, o_ready, o_mem_req, o_mem_addr
    );

    modport slave (
        output i_req, i_addr, i_mem_data, i_mem_ready,
        input  o_data, o_ready, o_mem_req, o_mem_addr
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch buffer: serves i-cache refills from a FIFO of sequentially fetched words.
// Define ARVI_PREFETCH_EN to enable the FIFO and speculative reads; otherwise every refill is a direct read.
module ifetch_prefetch #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    ifetch_prefetch_if.master bus
);

`ifdef ARVI_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [XLEN-1:0] word_t;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_STALE} mem_state_e;

    function automatic word_t align(input word_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    mem_state_e     state_q, state_d;
    word_t          mem_addr_q, mem_addr_d;
    word_t          head_addr_q, head_addr_d;
    word_t          miss_addr_q, miss_addr_d;
    logic           pending_q, pending_d;
    logic           ready_q, ready_d;
    word_t          data_q, data_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    word_t          fifo_q [DEPTH];

    logic           push_en;
    logic [PW-1:0]  push_ptr;
    logic           req_eval, hit, miss, resp, mem_free;
    word_t          fill_addr;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        head_addr_d = head_addr_q;
        miss_addr_d = miss_addr_q;
        pending_d   = pending_q;
        ready_d     = 1'b0;
        data_d      = data_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        push_en     = 1'b0;
        push_ptr    = rd_ptr_q + PW'(count_q);

        req_eval = bus.i_req && !ready_q && !pending_q;
        hit      = PF_EN && req_eval && (count_q != '0)
                   && (bus.i_addr[XLEN-1:2] == head_addr_q[XLEN-1:2]);
        miss     = req_eval && !hit;
        resp     = bus.i_mem_ready && (state_q != ST_IDLE);

        if (hit) begin
            data_d      = fifo_q[rd_ptr_q];
            ready_d     = 1'b1;
            rd_ptr_d    = rd_ptr_q + PW'(1);
            head_addr_d = head_addr_q + word_t'(4);
            count_d     = count_q - CW'(1);
        end else if (miss) begin
            count_d     = '0;
            pending_d   = 1'b1;
            miss_addr_d = align(bus.i_addr);
        end

        // A miss recorded this cycle is visible here, so a read to the same word that lands now is forwarded.
        if (resp) begin
            if (state_q == ST_STALE) begin
                data_d = data_q;
            end else if (pending_d && (mem_addr_q[XLEN-1:2] == miss_addr_d[XLEN-1:2])) begin
                data_d      = bus.i_mem_data;
                ready_d     = 1'b1;
                pending_d   = 1'b0;
                head_addr_d = miss_addr_d + word_t'(4);
            end else if (!pending_d && PF_EN && (count_d != CW'(DEPTH))) begin
                push_en = 1'b1;
                count_d = count_d + CW'(1);
            end
        end

        mem_free  = resp || (state_q == ST_IDLE);
        fill_addr = head_addr_d + word_t'({count_d, 2'b00});

        if (mem_free) begin
            if (pending_d) begin
                state_d    = ST_FETCH;
                mem_addr_d = miss_addr_d;
            end else if (PF_EN && (count_d != CW'(DEPTH))) begin
                state_d    = ST_FETCH;
                mem_addr_d = fill_addr;
            end else begin
                state_d    = ST_IDLE;
            end
        end else if (miss && (state_q == ST_FETCH)
                     && (mem_addr_q[XLEN-1:2] != miss_addr_d[XLEN-1:2])) begin
            state_d = ST_STALE;
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge value of its _d input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            head_addr_q <= '0;
            miss_addr_q <= '0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b0;
            data_q      <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            head_addr_q <= head_addr_d;
            miss_addr_q <= miss_addr_d;
            pending_q   <= pending_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; entries are only read when count_q says they were written.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            fifo_q[push_ptr] <= bus.i_mem_data;
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_data     = data_q;
    assign bus.o_mem_req  = (state_q != ST_IDLE);
    assign bus.o_mem_addr = mem_addr_q;

endmodule
